// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: branch operation encodings and the
// redirect FSM state type used by the EX-stage branch resolution logic.
package pipe_pkg;

    // Branch operation encodings carried on br_op; 6 and 7 behave as NONE.
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_JMP  = 3'd5
    } br_op_e;

    // Redirect request state: nothing outstanding, or a redirect waiting for fetch.
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_PEND = 1'b1
    } rd_state_e;

endpackage

// File: rtl/branch_target_unit_if.sv
// EX-stage branch bus: instruction handshake, operands, registered result
// and the fetch redirect handshake. The pipeline side is the master and
// the branch unit is the slave.
interface branch_target_unit_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 stall;
    logic                 flush;
    logic [WIDTH-1:0]     post_pc;
    logic [WIDTH-1:0]     imm;
    logic [WIDTH-1:0]     rs_data;
    logic [WIDTH-1:0]     rt_data;
    logic [2:0]           br_op;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_target;
    logic                 out_taken;
    logic                 redirect_valid;
    logic [WIDTH-1:0]     redirect_pc;
    logic                 redirect_ready;
    logic [CNT_WIDTH-1:0] taken_count;

    // Pipeline / fetch side.
    modport master (
        output in_valid, stall, flush, post_pc, imm, rs_data, rt_data, br_op,
               redirect_ready,
        input  in_ready, out_valid, out_target, out_taken, redirect_valid,
               redirect_pc, taken_count
    );

    // Branch unit side.
    modport slave (
        input  in_valid, stall, flush, post_pc, imm, rs_data, rt_data, br_op,
               redirect_ready,
        output in_ready, out_valid, out_target, out_taken, redirect_valid,
               redirect_pc, taken_count
    );
endinterface

// File: rtl/branch_target_unit_cond.sv
// Branch condition evaluator: purely combinational br_op/rs/rt -> taken.
// Kept standalone so an ID-stage early-resolution block can share it.
module branch_cond
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       br_op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             taken
);

    logic rs_is_zero;
    logic rs_is_neg;

    assign rs_is_zero = (rs == '0);
    assign rs_is_neg  = rs[WIDTH-1];

    // Select the condition for the current branch type.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        taken = 1'b0;
        case (br_op)
            BR_BEQ:  taken = (rs == rt);
            BR_BNE:  taken = (rs != rt);
            BR_BLEZ: taken = rs_is_neg || rs_is_zero;
            BR_BGTZ: taken = !rs_is_neg && !rs_is_zero;
            BR_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_target_unit.sv
// EX-stage branch resolution: target adder, condition evaluation, EX/MEM
// output register with stall/flush, fetch redirect handshake and a
// saturating taken-branch counter.
module branch_target_unit
    import pipe_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SHIFT     = 2,
    parameter int CNT_WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    branch_target_unit_if.slave bus
);

    logic [WIDTH-1:0]     target;
    logic                 cond_taken;
    logic                 in_ready;
    logic                 accept;
    logic                 taken_accept;
    logic                 load_redirect;

    rd_state_e            state;
    rd_state_e            state_next;

    logic                 out_valid;
    logic [WIDTH-1:0]     out_target;
    logic                 out_taken;
    logic [WIDTH-1:0]     redirect_pc;
    logic [CNT_WIDTH-1:0] taken_count;

    // Target: incremented PC plus the byte offset; bits shifted out of the
    // immediate and the carry out of the adder are both dropped.
    assign target = bus.post_pc + (bus.imm << SHIFT);

    branch_cond #(
        .WIDTH (WIDTH)
    ) u_cond (
        .br_op (bus.br_op),
        .rs    (bus.rs_data),
        .rt    (bus.rt_data),
        .taken (cond_taken)
    );

    // A stall, or a redirect that fetch has not yet taken, holds the stage.
    // Flush deliberately does not gate in_ready; it only blocks acceptance.
    assign in_ready     = !bus.stall && !((state == RD_PEND) && !bus.redirect_ready);
    assign accept       = bus.in_valid && in_ready && !bus.flush;
    assign taken_accept = accept && cond_taken;

    // Redirect state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Redirect next-state: a new taken branch always (re)arms the request,
    // otherwise a pending request retires when fetch is ready.
    always_comb begin
        state_next    = state;
        load_redirect = 1'b0;
        if (bus.flush) begin
            state_next = RD_IDLE;
        end else begin
            case (state)
                RD_IDLE: begin
                    if (taken_accept) begin
                        state_next    = RD_PEND;
                        load_redirect = 1'b1;
                    end
                end
                RD_PEND: begin
                    if (taken_accept) begin
                        state_next    = RD_PEND;
                        load_redirect = 1'b1;
                    end else if (bus.redirect_ready) begin
                        state_next = RD_IDLE;
                    end
                end
                default: state_next = RD_IDLE;
            endcase
        end
    end

    // Redirect address: only changes when a new taken branch is accepted,
    // which keeps it stable while fetch is withholding ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc <= '0;
        end else if (load_redirect) begin
            redirect_pc <= target;
        end
    end

    // EX/MEM output register: flush kills, otherwise load when the stage moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_target <= '0;
            out_taken  <= 1'b0;
        end else if (bus.flush) begin
            out_valid <= 1'b0;
            out_taken <= 1'b0;
        end else if (in_ready) begin
            if (bus.in_valid) begin
                out_valid  <= 1'b1;
                out_target <= target;
                out_taken  <= cond_taken;
            end else begin
                out_valid <= 1'b0;
                out_taken <= 1'b0;
            end
        end
    end

    // Taken-branch counter, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_count <= '0;
        end else if (taken_accept && (taken_count != '1)) begin
            taken_count <= taken_count + CNT_WIDTH'(1);
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid;
    assign bus.out_target     = out_target;
    assign bus.out_taken      = out_taken;
    assign bus.redirect_valid = (state == RD_PEND);
    assign bus.redirect_pc    = redirect_pc;
    assign bus.taken_count    = taken_count;

    // Fetch must see a constant address for as long as it stalls the redirect.
    a_redirect_stable : assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.redirect_valid && !bus.redirect_ready) |=> $stable(redirect_pc)
    );

    // Once saturated the counter never wraps back.
    a_count_saturates : assert property (
        @(posedge clk) disable iff (!rst_n)
        (taken_count == '1) |=> (taken_count == '1)
    );

endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit: a 16-bit-counter instance and a
// 2-bit-counter instance share the same stimulus. The driver predicts the
// post-edge state from the branch rules and queues it; a monitor pops one
// prediction after every edge and compares it with both units.
module tb_branch_target_unit;
    import pipe_pkg::*;

    localparam int W     = 32;
    localparam int SHIFT = 2;

    typedef struct {
        logic          ov;
        logic [W-1:0]  tgt;
        logic          tk;
        logic          rv;
        logic [W-1:0]  rpc;
        logic [15:0]   cnt;
        logic [1:0]    cnt2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_target_unit_if #(.WIDTH(W), .CNT_WIDTH(16)) bus ();
    branch_target_unit_if #(.WIDTH(W), .CNT_WIDTH(2))  bus2 ();

    assign bus2.in_valid       = bus.in_valid;
    assign bus2.stall          = bus.stall;
    assign bus2.flush          = bus.flush;
    assign bus2.post_pc        = bus.post_pc;
    assign bus2.imm            = bus.imm;
    assign bus2.rs_data        = bus.rs_data;
    assign bus2.rt_data        = bus.rt_data;
    assign bus2.br_op          = bus.br_op;
    assign bus2.redirect_ready = bus.redirect_ready;

    branch_target_unit #(.WIDTH(W), .SHIFT(SHIFT), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    branch_target_unit #(.WIDTH(W), .SHIFT(SHIFT), .CNT_WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    // Reference state, described in terms of what the unit should present.
    bit          m_pend;
    logic [W-1:0] m_rpc;
    bit          m_ov;
    logic [W-1:0] m_tgt;
    bit          m_tk;
    int          m_cnt;
    int          m_cnt2;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
        case (op)
            3'd1:    return rs == rt;
            3'd2:    return rs != rt;
            3'd3:    return $signed(rs) <= 0;
            3'd4:    return $signed(rs) > 0;
            3'd5:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0; m_rpc = '0; m_ov = 0; m_tgt = '0; m_tk = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    // One clock of stimulus: drive, check in_ready, predict the next edge.
    task automatic step(input bit iv, input bit st, input bit fl, input logic [W-1:0] pc,
                        input logic [W-1:0] im, input logic [W-1:0] rs, input logic [W-1:0] rt,
                        input logic [2:0] op, input bit rr);
        bit           ready;
        bit           tk;
        logic [W-1:0] tgt;
        exp_t         e;
        @(negedge clk);
        bus.in_valid = iv; bus.stall = st; bus.flush = fl; bus.post_pc = pc;
        bus.imm = im; bus.rs_data = rs; bus.rt_data = rt; bus.br_op = op;
        bus.redirect_ready = rr;
        #1;
        ready = !st && !(m_pend && !rr);
        check("in_ready", {31'b0, bus.in_ready}, {31'b0, ready});
        tk  = ref_taken(op, rs, rt);
        tgt = pc + im * (1 << SHIFT);
        if (fl) begin
            m_ov = 0; m_tk = 0; m_pend = 0;
        end else begin
            if (ready) begin
                if (iv) begin
                    m_ov = 1; m_tgt = tgt; m_tk = tk;
                end else begin
                    m_ov = 0;
                end
            end
            if (iv && ready && tk) begin
                m_pend = 1; m_rpc = tgt;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end else if (m_pend && rr) begin
                m_pend = 0;
            end
        end
        e.ov = m_ov; e.tgt = m_tgt; e.tk = m_tk; e.rv = m_pend; e.rpc = m_rpc;
        e.cnt = 16'(m_cnt); e.cnt2 = 2'(m_cnt2);
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit rr);
        step(0, 0, 0, '0, '0, '0, '0, 3'd0, rr);
    endtask

    // Monitor: after every edge, compare the DUTs with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_valid", {31'b0, bus.out_valid}, {31'b0, e.ov});
                if (e.ov) begin
                    check("out_target", bus.out_target, e.tgt);
                    check("out_taken", {31'b0, bus.out_taken}, {31'b0, e.tk});
                end
                check("redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, e.rv});
                if (e.rv) check("redirect_pc", bus.redirect_pc, e.rpc);
                check("taken_count", {16'b0, bus.taken_count}, {16'b0, e.cnt});
                check("taken_count_w2", {30'b0, bus2.taken_count}, {30'b0, e.cnt2});
            end
        end
    end

    initial begin
        bit           iv, st, fl, rr;
        logic [2:0]   op;
        logic [W-1:0] rs, rt, pc, im;

        bus.in_valid = 0; bus.stall = 0; bus.flush = 0; bus.post_pc = '0; bus.imm = '0;
        bus.rs_data = '0; bus.rt_data = '0; bus.br_op = 3'd0; bus.redirect_ready = 0;
        model_reset();

        // Reset values while held in reset.
        #12;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_taken", {31'b0, bus.out_taken}, 32'd0);
        check("rst_out_target", bus.out_target, 32'd0);
        check("rst_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
        check("rst_redirect_pc", bus.redirect_pc, 32'd0);
        check("rst_taken_count", {16'b0, bus.taken_count}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Taken BEQ, fetch not ready.
        step(1, 0, 0, 32'h0040_0004, 32'h0000_0003, 32'd5, 32'd5, 3'd1, 0);
        @(posedge clk); #2;
        check("plan_beq_target", bus.out_target, 32'h0040_0010);
        check("plan_beq_rpc", bus.redirect_pc, 32'h0040_0010);
        check("plan_beq_count", {16'b0, bus.taken_count}, 32'd1);

        // Redirect held off for three cycles, then a ready pulse with a new taken BNE.
        repeat (3) step(1, 0, 0, 32'h0000_2000, 32'h0000_0020, 32'd1, 32'd2, 3'd2, 0);
        step(1, 0, 0, 32'h0000_1000, 32'h0000_0010, 32'd1, 32'd2, 3'd2, 1);
        idle(1);

        // Negative offset wrapping below zero.
        step(1, 0, 0, 32'h0000_0004, 32'hFFFF_FFFE, 32'd0, 32'd0, 3'd5, 1);
        @(posedge clk); #2;
        check("plan_jmp_wrap", bus.out_target, 32'hFFFF_FFFC);
        idle(1);

        // BLEZ then BGTZ across negative, zero and positive rs.
        step(1, 0, 0, 32'h100, 32'h1, 32'h8000_0000, 32'd0, 3'd3, 1);
        step(1, 0, 0, 32'h200, 32'h2, 32'h0000_0000, 32'd0, 3'd3, 1);
        step(1, 0, 0, 32'h300, 32'h3, 32'h0000_0001, 32'd0, 3'd3, 1);
        step(1, 0, 0, 32'h400, 32'h4, 32'h8000_0000, 32'd0, 3'd4, 1);
        step(1, 0, 0, 32'h500, 32'h5, 32'h0000_0000, 32'd0, 3'd4, 1);
        step(1, 0, 0, 32'h600, 32'h6, 32'h0000_0001, 32'd0, 3'd4, 1);
        idle(1);

        // Flush while a redirect is pending and the stage is stalled.
        step(1, 0, 0, 32'h700, 32'h7, 32'd0, 32'd0, 3'd5, 0);
        step(1, 1, 1, 32'h800, 32'h8, 32'd0, 32'd0, 3'd5, 0);
        idle(0);

        // Asynchronous reset in the middle of a pending redirect.
        step(1, 0, 0, 32'h900, 32'h9, 32'd0, 32'd0, 3'd5, 0);
        @(negedge clk);
        bus.in_valid = 0; bus.stall = 0; bus.flush = 0; bus.br_op = 3'd0; bus.redirect_ready = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("async_out_target", bus.out_target, 32'd0);
        check("async_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
        check("async_redirect_pc", bus.redirect_pc, 32'd0);
        check("async_taken_count", {16'b0, bus.taken_count}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic with biased handshakes and operand patterns.
        for (int i = 0; i < 400; i++) begin
            iv = ($urandom_range(0, 9) < 7);
            st = ($urandom_range(0, 9) < 2);
            fl = ($urandom_range(0, 19) == 0);
            rr = ($urandom_range(0, 9) < 6);
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       rs = 32'd0;
                1:       rs = 32'h8000_0000 | $urandom;
                2:       rs = 32'($urandom_range(1, 100));
                default: rs = $urandom;
            endcase
            rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
            pc = $urandom;
            im = $urandom;
            step(iv, st, fl, pc, im, rs, rt, op, rr);
        end
        idle(1);
        @(posedge clk); #3;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_target_unit.md
# branch_target_unit

Parametrised EX-stage branch resolution block: successor to the plain combinational branch-target adder. Computes the branch/jump target from the incremented PC and the sign-extended immediate and evaluates the branch condition from the register operands. Registers the result into the EX/MEM boundary with stall and flush. Delivers a taken-branch redirect to fetch over a valid/ready handshake, with a saturating taken-branch counter for performance monitoring.

## Interface
- `WIDTH`, 32: datapath width (PC, immediate, operands).
- `SHIFT`, 2: left shift applied to the immediate (word offset to byte offset).
- `CNT_WIDTH`, 16: width of the taken-branch counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: EX-stage instruction valid.
- `in_ready` out 1: unit accepts the EX instruction this cycle.
- `stall` in 1: downstream hold; output register keeps its value.
- `flush` in 1: kill in-flight work; highest priority.
- `post_pc` in WIDTH: PC+4 of the instruction.
- `imm` in WIDTH: sign-extended immediate.
- `rs_data`, `rt_data` in WIDTH: operands.
- `br_op` in 3: NONE=0, BEQ=1, BNE=2, BLEZ=3, BGTZ=4, JMP=5; 6–7 treated as NONE.
- `out_valid` out 1: registered result valid.
- `out_target` out WIDTH: registered target.
- `out_taken` out 1: registered taken flag.
- `redirect_valid` out 1: redirect request to fetch.
- `redirect_pc` out WIDTH: redirect address.
- `redirect_ready` in 1: fetch accepts redirect.
- `taken_count` out CNT_WIDTH: saturating count of accepted taken branches.

## Operation
- Target: `post_pc + (imm << SHIFT)`, truncated mod 2^WIDTH; bits shifted out of `imm` are discarded.
- Taken: BEQ `rs==rt`; BNE `rs!=rt`; BLEZ `rs` signed ≤ 0; BGTZ `rs` signed > 0; JMP always; NONE never.
- `in_ready = !stall && !(state==PEND && !redirect_ready)`.
- Accept = `in_valid && in_ready`. On accept, the output register loads target, taken, and `out_valid=1`.
- When `in_ready=1 && !in_valid`, the register loads `out_valid=0`.
- When `in_ready=0`, all output register fields hold.
- Redirect FSM has two states, IDLE and PEND.
  - IDLE → PEND on accept with taken=1; `redirect_pc` loads the target.
  - PEND → IDLE on `redirect_ready` with no new taken accept.
  - PEND with `redirect_ready` plus a new taken accept stays PEND; `redirect_pc` loads the new target.
  - `redirect_valid = (state==PEND)`. `redirect_pc` is stable while `redirect_valid && !redirect_ready`.
- `taken_count` increments by 1 per accepted taken branch and saturates at 2^CNT_WIDTH−1.
- `flush` overrides every other input. Next edge: `out_valid=0`, `out_taken=0`, state=IDLE, nothing accepted, counter unchanged. `in_ready` is not gated by flush.

## Timing
- Reset values: `out_valid=0`, `out_taken=0`, `out_target=0`, `redirect_valid=0`, `redirect_pc=0`, `taken_count=0`, state=IDLE. `in_ready` follows its equation, so it is 1 when `stall=0`.
- Reset takes effect immediately on `rst_n` low, independent of `clk`; a reset mid-PEND drops the redirect.
- Latency: accept at edge N gives `out_*` and `redirect_valid` valid after edge N.
- Redirect handshake completes on the edge where `redirect_valid && redirect_ready`; `redirect_valid` may deassert after that edge.
- `redirect_ready` is allowed while `redirect_valid=0` and has no effect.
- `stall` and a pending redirect both hold the output register. Neither blocks `flush`.
- Condition and target logic is combinational into the register: one adder plus one comparator between flops.

## Structure
- Shared package `pipe_pkg` holds the `br_op` encodings (BR_NONE … BR_JMP) and the FSM state type (RD_IDLE, RD_PEND). The `branch_target_unit` defines no other module-specific constants in the package.
- One natural sub-module, `branch_cond`: combinational, `br_op`/`rs`/`rt` → taken. It is reused by a later ID-stage early-resolution block.
- Target adder, output register, FSM and counter stay in the top module.

## Test plan
- WIDTH=32, BEQ, `post_pc=0x00400004`, `imm=0x00000003`, `rs=rt=5` → next cycle `out_target=0x00400010`, `out_taken=1`, `redirect_valid=1`, `redirect_pc=0x00400010`, `taken_count=1`.
- Negative offset and wrap: `post_pc=0x00000004`, `imm=0xFFFFFFFE`, JMP → `out_target=0xFFFFFFFC`, taken.
- Hold `redirect_ready=0` for 3 cycles after a taken branch with `in_valid=1` → `in_ready=0`, `redirect_pc` stable. Ready pulse with a new taken BNE accepted → stays PEND, `redirect_pc` updates.
- BLEZ/BGTZ with `rs=0x80000000`, then 0, then 1 → BLEZ taken, taken, not; BGTZ not, not, taken.
- `flush` asserted while PEND and `stall=1` → next cycle `redirect_valid=0`, `out_valid=0`, `taken_count` unchanged. `rst_n` low mid-cycle clears all outputs without a clock edge.
- CNT_WIDTH=2, 5 consecutive taken branches → `taken_count` reads 1, 2, 3, 3, 3.
